// File: rtl/game_state_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : game_state_ctrl
// Description : Top-level game sequencer. Gates the frog controller with a
//               game-active enable, turns collision-checker hits and round
//               timeouts into a one-cycle respawn pulse, and owns lives, the
//               per-life countdown, the death pause, game over and win.
//
// Ports       : i_Clk         - system clock
//               i_Rst_L       - asynchronous active-low reset
//               i_Start       - debounced start button (level)
//               i_Hit         - frog overlaps a hazard (level)
//               i_Score[6:0]  - current score from the frog controller
//               o_Game_Active - high only while in PLAY
//               o_Collided    - one-cycle respawn request
//               o_Lives[2:0]  - remaining lives
//               o_Time_Left   - seconds remaining in the current life
//               o_State[2:0]  - IDLE=0, PLAY=1, DYING=2, GAME_OVER=3, WIN=4
//
// Revision    : 1.0 - initial release
// ============================================================================
module game_state_ctrl #(
  parameter int LIVES_INIT     = 3,
  parameter int ROUND_SECONDS  = 30,
  parameter int CLKS_PER_SEC   = 25000000,
  parameter int CLKS_PER_DEATH = 12500000,
  parameter int WIN_SCORE      = 5
) (
  input  logic       i_Clk,
  input  logic       i_Rst_L,
  input  logic       i_Start,
  input  logic       i_Hit,
  input  logic [6:0] i_Score,
  output logic       o_Game_Active,
  output logic       o_Collided,
  output logic [2:0] o_Lives,
  output logic [5:0] o_Time_Left,
  output logic [2:0] o_State
);

  localparam logic [2:0] c_ST_IDLE      = 3'd0;
  localparam logic [2:0] c_ST_PLAY      = 3'd1;
  localparam logic [2:0] c_ST_DYING     = 3'd2;
  localparam logic [2:0] c_ST_GAME_OVER = 3'd3;
  localparam logic [2:0] c_ST_WIN       = 3'd4;

  // Guard against a terminal count of 1, where $clog2 would yield 0 bits.
  localparam int c_SEC_W = (CLKS_PER_SEC   > 1) ? $clog2(CLKS_PER_SEC)   : 1;
  localparam int c_DTH_W = (CLKS_PER_DEATH > 1) ? $clog2(CLKS_PER_DEATH) : 1;

  localparam logic [c_SEC_W-1:0] c_SEC_LAST   = c_SEC_W'(CLKS_PER_SEC - 1);
  localparam logic [c_DTH_W-1:0] c_DTH_LAST   = c_DTH_W'(CLKS_PER_DEATH - 1);
  localparam logic [2:0]         c_LIVES_INIT = 3'(LIVES_INIT);
  localparam logic [5:0]         c_ROUND      = 6'(ROUND_SECONDS);
  localparam logic [6:0]         c_WIN_SCORE  = 7'(WIN_SCORE);

  logic [2:0]         r_state,     w_state_nxt;
  logic [2:0]         r_lives,     w_lives_nxt;
  logic [5:0]         r_time,      w_time_nxt;
  logic [c_SEC_W-1:0] r_sec_cnt,   w_sec_nxt;
  logic [c_DTH_W-1:0] r_death_cnt, w_death_nxt;
  logic               r_collided,  w_collided_nxt;
  logic               r_prev_start;

  logic w_start_pulse;
  logic w_sec_wrap;
  logic w_timeout;
  logic w_win;

  assign w_start_pulse = i_Start & ~r_prev_start;
  assign w_sec_wrap    = (r_sec_cnt == c_SEC_LAST);
  // Timeout is the wrap that would take the countdown from 1 to 0.
  assign w_timeout     = w_sec_wrap && (r_time == 6'd1);
  assign w_win         = (i_Score >= c_WIN_SCORE);

  always_comb begin
    w_state_nxt    = r_state;
    w_lives_nxt    = r_lives;
    w_time_nxt     = r_time;
    w_sec_nxt      = r_sec_cnt;
    w_death_nxt    = r_death_cnt;
    w_collided_nxt = 1'b0;

    case (r_state)
      c_ST_PLAY: begin
        // The countdown keeps running on the cycle a win or death is taken.
        if (w_sec_wrap) begin
          w_sec_nxt = '0;
          if (r_time != 6'd0) begin
            w_time_nxt = r_time - 6'd1;
          end
        end else begin
          w_sec_nxt = r_sec_cnt + 1'b1;
        end

        // Win outranks death; a hit coinciding with timeout is one death.
        if (w_win) begin
          w_state_nxt = c_ST_WIN;
        end else if (i_Hit || w_timeout) begin
          w_collided_nxt = 1'b1;
          if (r_lives > 3'd1) begin
            w_lives_nxt = r_lives - 3'd1;
            w_state_nxt = c_ST_DYING;
            w_death_nxt = '0;
          end else begin
            w_lives_nxt = 3'd0;
            w_state_nxt = c_ST_GAME_OVER;
          end
        end
      end

      c_ST_DYING: begin
        if (r_death_cnt == c_DTH_LAST) begin
          w_state_nxt = c_ST_PLAY;
          w_time_nxt  = c_ROUND;
          w_sec_nxt   = '0;
        end else begin
          w_death_nxt = r_death_cnt + 1'b1;
        end
      end

      // IDLE, GAME_OVER and WIN hold everything until a fresh start press.
      default: begin
        if (w_start_pulse) begin
          w_state_nxt = c_ST_PLAY;
          w_lives_nxt = c_LIVES_INIT;
          w_time_nxt  = c_ROUND;
          w_sec_nxt   = '0;
          w_death_nxt = '0;
        end
      end
    endcase
  end

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      r_state      <= c_ST_IDLE;
      r_lives      <= c_LIVES_INIT;
      r_time       <= c_ROUND;
      r_sec_cnt    <= '0;
      r_death_cnt  <= '0;
      r_collided   <= 1'b0;
      // Held high so a button pressed through reset does not start a game.
      r_prev_start <= 1'b1;
    end else begin
      r_state      <= w_state_nxt;
      r_lives      <= w_lives_nxt;
      r_time       <= w_time_nxt;
      r_sec_cnt    <= w_sec_nxt;
      r_death_cnt  <= w_death_nxt;
      r_collided   <= w_collided_nxt;
      r_prev_start <= i_Start;
    end
  end

  assign o_State       = r_state;
  assign o_Game_Active = (r_state == c_ST_PLAY);
  assign o_Collided    = r_collided;
  assign o_Lives       = r_lives;
  assign o_Time_Left   = r_time;

endmodule
`default_nettype wire
